// File: rtl/calc_pkg.sv
// Shared definitions for the UART hex calculator: opcodes, ASCII codes and parser states.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam logic [7:0] CHR_EQ    = 8'h3D;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SP    = 8'h20;
  localparam logic [7:0] CHR_PLUS  = 8'h2B;
  localparam logic [7:0] CHR_MINUS = 8'h2D;
  localparam logic [7:0] CHR_STAR  = 8'h2A;
  localparam logic [7:0] CHR_AMP   = 8'h26;
  localparam logic [7:0] CHR_PIPE  = 8'h7C;
  localparam logic [7:0] CHR_CARET = 8'h5E;

  typedef enum logic [1:0] {
    S_OPA   = 2'd0,
    S_OPB   = 2'd1,
    S_ISSUE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/hex_ascii_to_nibble.sv
// Combinational classifier for one ASCII byte: hex digit value and operator code.
module hex_ascii_to_nibble
  import calc_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] nibble,
  output logic       is_op,
  output logic [2:0] op_code
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nibble = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 yields 10..15 for either case
      is_hex = 1'b1;
      nibble = ch[3:0] + 4'd9;
    end
  end

  always_comb begin
    is_op   = 1'b1;
    op_code = OP_ADD;
    case (ch)
      CHR_PLUS:  op_code = OP_ADD;
      CHR_MINUS: op_code = OP_SUB;
      CHR_STAR:  op_code = OP_MUL;
      CHR_AMP:   op_code = OP_AND;
      CHR_PIPE:  op_code = OP_OR;
      CHR_CARET: op_code = OP_XOR;
      default:   is_op   = 1'b0;
    endcase
  end

endmodule

// File: rtl/hex_cmd_decoder.sv
// Parses "<hexA><op><hexB><term>" from the UART byte stream into ALU operands and a start pulse.
module hex_cmd_decoder
  import calc_pkg::*;
#(
  parameter int         MAX_DIGITS = 8,
  parameter logic [7:0] TERM_CHAR  = 8'h3D
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_in,
  input  logic        uin_valid,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [2:0]  opcode,
  output logic        alu_start,
  output logic        parse_err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t      state, next_state;
  logic [31:0] acc_a, acc_b;
  logic [2:0]  opc_q;
  logic [3:0]  cnt;

  logic       is_hex, is_op;
  logic [3:0] nibble;
  logic [2:0] op_code;
  logic       byte_v, is_term, digit_ok, err_evt, clr_acc;
  logic       start_d, err_d;

  hex_ascii_to_nibble u_cls (
    .ch      (uart_in),
    .is_hex  (is_hex),
    .nibble  (nibble),
    .is_op   (is_op),
    .op_code (op_code)
  );

  assign byte_v   = uin_valid && (uart_in != CHR_SP);
  assign is_term  = (uart_in == TERM_CHAR) || (uart_in == CHR_CR);
  assign digit_ok = is_hex && (cnt < MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OPA;
    else     state <= next_state;
  end

  // A bad terminator both reports the error and ends the command, so it returns straight to S_OPA
  always_comb begin
    next_state = state;
    err_evt    = 1'b0;
    case (state)
      S_OPA: if (byte_v && !digit_ok) begin
        if (is_op && cnt != 4'd0) next_state = S_OPB;
        else begin
          err_evt    = 1'b1;
          next_state = is_term ? S_OPA : S_ERR;
        end
      end
      S_OPB: if (byte_v && !digit_ok) begin
        if (is_term && cnt != 4'd0) next_state = S_ISSUE;
        else begin
          err_evt    = 1'b1;
          next_state = is_term ? S_OPA : S_ERR;
        end
      end
      S_ISSUE: begin
        err_evt    = byte_v;
        next_state = S_OPA;
      end
      S_ERR: if (byte_v && is_term) next_state = S_OPA;
      default: next_state = S_OPA;
    endcase
  end

  always_comb begin
    start_d = (state == S_ISSUE);
    err_d   = err_evt;
  end

  assign clr_acc = (state == S_ISSUE) || (byte_v && is_term && next_state == S_OPA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_a <= '0;
      acc_b <= '0;
      opc_q <= OP_ADD;
      cnt   <= '0;
    end else if (clr_acc) begin
      acc_a <= '0;
      acc_b <= '0;
      cnt   <= '0;
    end else if (byte_v && digit_ok && state == S_OPA) begin
      acc_a <= {acc_a[27:0], nibble};
      cnt   <= cnt + 4'd1;
    end else if (byte_v && digit_ok && state == S_OPB) begin
      acc_b <= {acc_b[27:0], nibble};
      cnt   <= cnt + 4'd1;
    end else if (state == S_OPA && next_state == S_OPB) begin
      opc_q <= op_code;
      cnt   <= '0;
    end
  end

  // Output register stage: operands move only together with the start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      opcode    <= '0;
      alu_start <= 1'b0;
      parse_err <= 1'b0;
    end else begin
      alu_start <= start_d;
      parse_err <= err_d;
      if (start_d) begin
        op_a   <= acc_a;
        op_b   <= acc_b;
        opcode <= opc_q;
      end
    end
  end

endmodule

// File: tb/tb_hex_cmd_decoder.sv
// Bench for hex_cmd_decoder: command table with a scoreboard of expected ALU issues.
module tb_hex_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  uart_in = 8'h00;
  logic        uin_valid = 1'b0;
  logic [31:0] op_a, op_b;
  logic [2:0]  opcode;
  logic        alu_start, parse_err;

  hex_cmd_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .uart_in   (uart_in),
    .uin_valid (uin_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .opcode    (opcode),
    .alu_start (alu_start),
    .parse_err (parse_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       cmd;   // '#' stands for CR
    int          n_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          n_err;
  } vec_t;

  vec_t        vecs[11];
  logic [66:0] sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          start_cnt = 0;
  int          err_cnt = 0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every start pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (parse_err) err_cnt++;
      if (alu_start) begin
        start_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_start", {op_a, op_b, opcode}, 67'd0);
        end else begin
          check("issue_operands", {op_a, op_b, opcode}, sb_q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_in   = b;
    uin_valid = 1'b1;
    @(negedge clk);
    uin_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i] == "#" ? 8'h0D : s[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{"12+34=",             1, 32'h12,       32'h34,       3'd0, 0};
    vecs[1]  = '{"ffffffff*2#",        1, 32'hFFFFFFFF, 32'h2,        3'd2, 0};
    vecs[2]  = '{"DeAd ^ bEeF=",       1, 32'hDEAD,     32'hBEEF,     3'd5, 0};
    vecs[3]  = '{"123456789+1=",       0, 32'h0,        32'h0,        3'd0, 1};
    vecs[4]  = '{"5-3=",               1, 32'h5,        32'h3,        3'd1, 0};
    vecs[5]  = '{"+5=",                0, 32'h0,        32'h0,        3'd0, 1};
    vecs[6]  = '{"7+=",                0, 32'h0,        32'h0,        3'd0, 1};
    vecs[7]  = '{"7+G=",               0, 32'h0,        32'h0,        3'd0, 1};
    vecs[8]  = '{"a&F0=",              1, 32'hA,        32'hF0,       3'd3, 0};
    vecs[9]  = '{"1|2#",               1, 32'h1,        32'h2,        3'd4, 0};
    vecs[10] = '{"12345678+87654321=", 1, 32'h12345678, 32'h87654321, 3'd0, 0};

    idle(2);
    check("reset_outputs", {op_a, op_b, opcode, alu_start, parse_err}, 67'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 11; v++) begin
      int s0, e0;
      s0 = start_cnt;
      e0 = err_cnt;
      if (vecs[v].n_start != 0) sb_q.push_back({vecs[v].a, vecs[v].b, vecs[v].op});
      send_str(vecs[v].cmd);
      idle(4);
      check({"starts:", vecs[v].cmd}, 67'(start_cnt - s0), 67'(vecs[v].n_start));
      check({"errs:", vecs[v].cmd}, 67'(err_cnt - e0), 67'(vecs[v].n_err));
    end

    // Reset in the middle of a command discards the partial operands
    begin
      int s0, e0;
      send_str("AB+");
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      check("mid_reset_outputs", {op_a, op_b, opcode, alu_start, parse_err}, 67'd0);
      rst = 1'b0;
      s0 = start_cnt;
      e0 = err_cnt;
      sb_q.push_back({32'h1, 32'h1, 3'd1});
      send_str("1-1=");
      idle(4);
      check("reset_recover_starts", 67'(start_cnt - s0), 67'd1);
      check("reset_recover_errs", 67'(err_cnt - e0), 67'd0);
    end

    // A byte strobed in the issue cycle is dropped and flagged
    begin
      int s0, e0;
      s0 = start_cnt;
      e0 = err_cnt;
      sb_q.push_back({32'h1, 32'h2, 3'd0});
      send_str("1+2");
      @(negedge clk);
      uart_in   = "=";
      uin_valid = 1'b1;
      @(negedge clk);
      uart_in   = "7";
      @(negedge clk);
      uin_valid = 1'b0;
      idle(4);
      check("collide_starts", 67'(start_cnt - s0), 67'd1);
      check("collide_errs", 67'(err_cnt - e0), 67'd1);
      sb_q.push_back({32'h3, 32'h4, 3'd2});
      send_str("3*4=");
      idle(4);
      check("after_collide_starts", 67'(start_cnt - s0), 67'd2);
    end

    check("scoreboard_drained", 67'(sb_q.size()), 67'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
